// File: rtl/execute_pkg.sv
// Shared types and encodings for the Execute stage and its multi-cycle unit.
package execute_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_MUL  = 2'b01,
    S_DIV  = 2'b10,
    S_DONE = 2'b11
  } state_t;

  // MulDivOp encodings; 2'b11 is reserved and falls through to the ALU path
  localparam logic [1:0] OP_ALU  = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_UDIV = 2'b10;

  // AluControl encodings understood by alu
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/execute_multicycle_if.sv
// Execute-stage bundle: decoded controls and operands in, results and hazard flags out.
interface execute_multicycle_if #(parameter int N = 64);
  logic         start_E;
  logic [1:0]   MulDivOp;
  logic         BranchToReg;
  logic [1:0]   AluSrc;
  logic [3:0]   AluControl;
  logic [N-1:0] PC_E;
  logic [N-1:0] signImm_E;
  logic [N-1:0] readData1_E;
  logic [N-1:0] readData2_E;
  logic [N-1:0] readData3_E;
  logic [N-1:0] PCBranch_E;
  logic [N-1:0] aluResult_E;
  logic [N-1:0] writeData_E;
  logic         zero_E;
  logic         stall_E;
  logic         done_E;

  // pipeline/decoder side
  modport master (
    output start_E, MulDivOp, BranchToReg, AluSrc, AluControl,
           PC_E, signImm_E, readData1_E, readData2_E, readData3_E,
    input  PCBranch_E, aluResult_E, writeData_E, zero_E, stall_E, done_E
  );

  // Execute stage side
  modport slave (
    input  start_E, MulDivOp, BranchToReg, AluSrc, AluControl,
           PC_E, signImm_E, readData1_E, readData2_E, readData3_E,
    output PCBranch_E, aluResult_E, writeData_E, zero_E, stall_E, done_E
  );
endinterface

// File: rtl/execute_blocks.sv
// Small datapath building blocks shared across the pipeline: mux2, mux4, sl2, adder, alu.
module mux2 #(parameter int W = 64) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         s,
  output logic [W-1:0] y
);
  assign y = s ? d1 : d0;
endmodule

module mux4 #(parameter int W = 64) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [1:0]   s,
  output logic [W-1:0] y
);
  // plain 4:1 select
  always_comb begin
    case (s)
      2'b00:   y = d0;
      2'b01:   y = d1;
      2'b10:   y = d2;
      default: y = d3;
    endcase
  end
endmodule

module sl2 #(parameter int W = 64) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);
  assign y = {a[W-3:0], 2'b00};
endmodule

module adder #(parameter int W = 64) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = a + b;
endmodule

module alu import execute_pkg::*; #(parameter int W = 64) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   ctrl,
  output logic [W-1:0] y
);
  // single-cycle integer operations; unknown codes yield zero
  always_comb begin
    y = '0;
    case (ctrl)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOR: y = ~(a | b);
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiplier (shift-add) and restoring divider, one bit per cycle.
module muldiv_iter #(parameter int N = 64) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,      // latch operands and arm the counter
  input  logic         load_div,  // selects divide for the operation being loaded
  input  logic         run,       // FSM is in an iteration state
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         cnt_zero,
  output logic [N-1:0] result
);
  localparam int CW = $clog2(N);

  logic [CW-1:0] cnt;
  logic          div_mode;
  logic [N-1:0]  op_a;   // multiplicand, shifted left each step
  logic [N-1:0]  op_b;   // multiplier (shifted right) or divisor (constant)
  logic [N-1:0]  acc;    // partial product or running remainder
  logic [N-1:0]  quo;    // dividend shifting out, quotient shifting in
  logic [N:0]    trial;

  // trial subtraction of the divisor from the remainder with the next dividend bit
  assign trial = {acc, quo[N-1]} - {1'b0, op_b};

  assign cnt_zero = (cnt == '0);
  assign result   = div_mode ? quo : acc;

  // operand latch and one iteration per cycle while running
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      div_mode <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      quo      <= '0;
    end else if (load) begin
      cnt      <= CW'(N-1);
      div_mode <= load_div;
      op_a     <= a;
      op_b     <= b;
      acc      <= '0;
      quo      <= a;
    end else if (run) begin
      if (cnt != '0) cnt <= cnt - CW'(1);
      if (div_mode) begin
        // divisor of zero always "fits", so the quotient fills with ones
        if (!trial[N]) begin
          acc <= trial[N-1:0];
          quo <= {quo[N-2:0], 1'b1};
        end else begin
          acc <= {acc[N-2:0], quo[N-1]};
          quo <= {quo[N-2:0], 1'b0};
        end
      end else begin
        if (op_b[0]) acc <= acc + op_a;
        op_a <= {op_a[N-2:0], 1'b0};
        op_b <= {1'b0, op_b[N-1:1]};
      end
    end
  end
endmodule

// File: rtl/execute_multicycle.sv
// Execute stage: zero-latency ALU and branch target, plus a stalling MUL/UDIV unit.
module execute_multicycle import execute_pkg::*; #(parameter int N = 64) (
  input  logic                 clk,
  input  logic                 reset,
  execute_multicycle_if.slave  bus
);
  state_t       state, state_nxt;
  logic         accept;
  logic         in_done;
  logic         cnt_zero;
  logic [N-1:0] src_b;
  logic [N-1:0] alu_out;
  logic [N-1:0] imm_sl2;
  logic [N-1:0] pc_rel;
  logic [N-1:0] iter_result;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next state; a new op is only considered from idle
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start_E && (bus.MulDivOp == OP_MUL || bus.MulDivOp == OP_UDIV)) begin
          accept    = 1'b1;
          state_nxt = (bus.MulDivOp == OP_MUL) ? S_MUL : S_DIV;
        end
      end
      S_MUL, S_DIV: if (cnt_zero) state_nxt = S_DONE;
      S_DONE:       state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  assign in_done     = (state == S_DONE);
  // reset gating keeps stall low even if an accept is presented during reset
  assign bus.stall_E = !reset && (accept || state == S_MUL || state == S_DIV);
  assign bus.done_E  = in_done;

  muldiv_iter #(.N(N)) u_iter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_div (bus.MulDivOp == OP_UDIV),
    .run      (state == S_MUL || state == S_DIV),
    .a        (bus.readData1_E),
    .b        (bus.readData2_E),
    .cnt_zero (cnt_zero),
    .result   (iter_result)
  );

  mux4 #(.W(N)) u_srcb (
    .d0 (bus.readData2_E),
    .d1 (bus.signImm_E),
    .d2 (bus.readData3_E),
    .d3 (bus.readData3_E),
    .s  (bus.AluSrc),
    .y  (src_b)
  );

  alu #(.W(N)) u_alu (
    .a    (bus.readData1_E),
    .b    (src_b),
    .ctrl (bus.AluControl),
    .y    (alu_out)
  );

  sl2 #(.W(N)) u_sl2 (
    .a (bus.signImm_E),
    .y (imm_sl2)
  );

  adder #(.W(N)) u_pcadd (
    .a (imm_sl2),
    .b (bus.PC_E),
    .y (pc_rel)
  );

  mux2 #(.W(N)) u_brsel (
    .d0 (pc_rel),
    .d1 (bus.readData1_E),
    .s  (bus.BranchToReg),
    .y  (bus.PCBranch_E)
  );

  mux2 #(.W(N)) u_ressel (
    .d0 (alu_out),
    .d1 (iter_result),
    .s  (in_done),
    .y  (bus.aluResult_E)
  );

  assign bus.writeData_E = bus.readData2_E;
  assign bus.zero_E      = (bus.aluResult_E == '0);

endmodule

// File: tb/tb_execute_multicycle.sv
// Directed bench for execute_multicycle at N = 64.
module tb_execute_multicycle;
  import execute_pkg::*;

  localparam int N = 64;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  execute_multicycle_if #(.N(N)) bus();

  execute_multicycle #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // issue one MUL/UDIV, count stall cycles, check the S_DONE cycle
  task automatic run_op(input string tag, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input bit perturb);
    int cyc;
    bus.readData1_E = a;
    bus.readData2_E = b;
    bus.MulDivOp    = op;
    bus.start_E     = 1'b1;
    #1;
    cyc = 0;
    while (bus.stall_E === 1'b1 && cyc < 200) begin
      cyc++;
      step();
      bus.start_E  = 1'b0;
      bus.MulDivOp = OP_ALU;
      if (perturb && cyc == 5) begin
        bus.readData1_E = 64'd200;
        bus.readData2_E = 64'd3;
        bus.MulDivOp    = OP_MUL;
        bus.start_E     = 1'b1;
      end
    end
    bus.start_E  = 1'b0;
    bus.MulDivOp = OP_ALU;
    chk({tag, "_stall_cycles"}, 64'(cyc), 64'd65);
    chk({tag, "_done"}, 64'(bus.done_E), 64'd1);
    chk({tag, "_result"}, bus.aluResult_E, exp);
    chk({tag, "_zero"}, 64'(bus.zero_E), (exp == 64'd0) ? 64'd1 : 64'd0);
    step();
    chk({tag, "_done_clear"}, 64'(bus.done_E), 64'd0);
    chk({tag, "_idle"}, 64'(dut.state), 64'(S_IDLE));
  endtask

  initial begin
    reset           = 1'b1;
    bus.start_E     = 1'b0;
    bus.MulDivOp    = OP_ALU;
    bus.BranchToReg = 1'b0;
    bus.AluSrc      = 2'b00;
    bus.AluControl  = ALU_AND;
    bus.PC_E        = '0;
    bus.signImm_E   = '0;
    bus.readData1_E = '0;
    bus.readData2_E = '0;
    bus.readData3_E = '0;
    #1;
    chk("rst_stall", 64'(bus.stall_E), 64'd0);
    chk("rst_done", 64'(bus.done_E), 64'd0);
    chk("rst_state", 64'(dut.state), 64'(S_IDLE));
    chk("rst_result", bus.aluResult_E, 64'd0);
    chk("rst_zero", 64'(bus.zero_E), 64'd1);
    step();
    step();
    reset = 1'b0;

    // ALU path, same-cycle results
    bus.AluControl  = ALU_ADD;
    bus.readData1_E = 64'd5;
    bus.readData2_E = 64'd7;
    bus.AluSrc      = 2'b00;
    #1;
    chk("alu_add", bus.aluResult_E, 64'd12);
    chk("alu_add_zero", 64'(bus.zero_E), 64'd0);
    chk("alu_add_stall", 64'(bus.stall_E), 64'd0);
    chk("write_data", bus.writeData_E, 64'd7);
    bus.AluSrc    = 2'b01;
    bus.signImm_E = 64'd4;
    #1;
    chk("alu_imm", bus.aluResult_E, 64'd9);
    bus.AluSrc      = 2'b11;
    bus.readData3_E = 64'hFFFF_FFFF_FFFF_FFFB;
    #1;
    chk("alu_rd3", bus.aluResult_E, 64'd0);
    chk("alu_rd3_zero", 64'(bus.zero_E), 64'd1);
    bus.AluControl = ALU_SUB;
    bus.AluSrc     = 2'b00;
    #1;
    chk("alu_sub", bus.aluResult_E, 64'hFFFF_FFFF_FFFF_FFFE);

    // reserved MulDivOp behaves as the ALU path
    bus.AluControl = ALU_ADD;
    bus.MulDivOp   = 2'b11;
    bus.start_E    = 1'b1;
    #1;
    chk("rsv_stall", 64'(bus.stall_E), 64'd0);
    chk("rsv_result", bus.aluResult_E, 64'd12);
    step();
    chk("rsv_state", 64'(dut.state), 64'(S_IDLE));
    bus.start_E  = 1'b0;
    bus.MulDivOp = OP_ALU;

    // branch target
    bus.PC_E        = 64'h100;
    bus.signImm_E   = 64'd4;
    bus.BranchToReg = 1'b0;
    #1;
    chk("br_pcrel", bus.PCBranch_E, 64'h110);
    bus.BranchToReg = 1'b1;
    bus.readData1_E = 64'h2000;
    #1;
    chk("br_reg", bus.PCBranch_E, 64'h2000);
    bus.BranchToReg = 1'b0;

    run_op("mul", OP_MUL, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
    run_op("div", OP_UDIV, 64'd100, 64'd7, 64'd14, 1'b1);
    run_op("div0", OP_UDIV, 64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    // reset in the 10th S_MUL cycle
    bus.readData1_E = 64'd5;
    bus.readData2_E = 64'd5;
    bus.MulDivOp    = OP_MUL;
    bus.start_E     = 1'b1;
    #1;
    chk("abort_accept_stall", 64'(bus.stall_E), 64'd1);
    step();
    bus.start_E  = 1'b0;
    bus.MulDivOp = OP_ALU;
    repeat (9) step();
    chk("abort_in_mul", 64'(dut.state), 64'(S_MUL));
    bus.BranchToReg = 1'b1;
    bus.readData1_E = 64'h2000;
    #1;
    chk("br_reg_in_mul", bus.PCBranch_E, 64'h2000);
    reset = 1'b1;
    #1;
    chk("abort_stall", 64'(bus.stall_E), 64'd0);
    chk("abort_done", 64'(bus.done_E), 64'd0);
    chk("abort_state", 64'(dut.state), 64'(S_IDLE));
    step();
    reset           = 1'b0;
    bus.BranchToReg = 1'b0;
    run_op("mul_after_rst", OP_MUL, 64'd6, 64'd7, 64'd42, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
